// File: rtl/fir_mac_sequencer.sv
// Sequences the circular sample RAM, coefficient ROM and DSP controls for one FIR output per accepted sample.
// Latency x_valid->y_valid N_TAPS+MEM_LAT+DSP_LAT+3; no backpressure: samples arriving while busy are dropped and set overrun.
module fir_mac_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int N_TAPS     = 317,
  parameter int ACC_WIDTH  = 48,
  parameter int SHIFT      = 15,
  parameter int MEM_LAT    = 2,
  parameter int DSP_LAT    = 3,
  localparam int AW        = $clog2(N_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] x_in,
  input  logic                         x_valid,
  output logic                         busy,
  output logic                         overrun,
  output logic                         buf_we,
  output logic [AW-1:0]                buf_waddr,
  output logic [DATA_WIDTH-1:0]        buf_wdata,
  output logic [AW-1:0]                buf_raddr,
  output logic [AW-1:0]                coef_addr,
  output logic                         mac_ce,
  output logic                         mac_first,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  output logic signed [DATA_WIDTH-1:0] y_out,
  output logic                         y_valid
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_MAC   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic [AW-1:0] LAST_TAP   = AW'(N_TAPS - 1);
  localparam logic [AW-1:0] LAST_DRAIN = AW'(MEM_LAT + DSP_LAT - 1);

  // Rounding is done one bit wider than the accumulator so the +half never wraps.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] HALF  = {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RW-1:0] Y_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] Y_MIN = ~Y_MAX;

  logic [2:0]            state;
  logic [AW-1:0]         k;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] sample;
  logic                  issue;
  logic                  issue_first;
  logic [MEM_LAT-1:0]    ce_sr;
  logic [MEM_LAT-1:0]    first_sr;

  logic signed [RW-1:0]         acc_ext;
  logic signed [RW-1:0]         rounded;
  logic signed [RW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] y_sat;

  always_comb begin
    acc_ext = {acc_in[ACC_WIDTH-1], acc_in};
    rounded = acc_ext + HALF;
    shifted = rounded >>> SHIFT;
    if (shifted > Y_MAX)      y_sat = Y_MAX[DATA_WIDTH-1:0];
    else if (shifted < Y_MIN) y_sat = Y_MIN[DATA_WIDTH-1:0];
    else                      y_sat = shifted[DATA_WIDTH-1:0];
  end

  // Issue flags travel with the registered addresses, then wait out the memory latency.
  assign mac_ce    = ce_sr[MEM_LAT-1];
  assign mac_first = first_sr[MEM_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_INIT;
      k           <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sample      <= '0;
      issue       <= 1'b0;
      issue_first <= 1'b0;
      ce_sr       <= '0;
      first_sr    <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      buf_we      <= 1'b0;
      buf_waddr   <= '0;
      buf_wdata   <= '0;
      buf_raddr   <= '0;
      coef_addr   <= '0;
      y_out       <= '0;
      y_valid     <= 1'b0;
    end else begin
      busy        <= (state != S_IDLE);
      buf_we      <= 1'b0;
      issue       <= 1'b0;
      issue_first <= 1'b0;
      y_valid     <= 1'b0;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        ce_sr[i]    <= ce_sr[i-1];
        first_sr[i] <= first_sr[i-1];
      end
      ce_sr[0]    <= issue;
      first_sr[0] <= issue_first;

      if (x_valid && (state != S_IDLE)) overrun <= 1'b1;

      case (state)
        S_INIT: begin
          buf_we    <= 1'b1;
          buf_waddr <= k;
          buf_wdata <= '0;
          if (k == LAST_TAP) begin
            k     <= '0;
            state <= S_IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_IDLE: begin
          if (x_valid) begin
            sample <= x_in;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          buf_we    <= 1'b1;
          buf_waddr <= wr_ptr;
          buf_wdata <= sample;
          rd_ptr    <= wr_ptr;
          k         <= '0;
          state     <= S_MAC;
        end
        S_MAC: begin
          buf_raddr   <= rd_ptr;
          coef_addr   <= k;
          issue       <= 1'b1;
          issue_first <= (k == '0);
          rd_ptr      <= (rd_ptr == '0) ? LAST_TAP : rd_ptr - 1'b1;
          if (k == LAST_TAP) begin
            k     <= '0;
            state <= S_DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (k == LAST_DRAIN) begin
            k     <= '0;
            state <= S_OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_OUT: begin
          y_out   <= y_sat;
          y_valid <= 1'b1;
          wr_ptr  <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          k     <= '0;
          state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: RAM/ROM/DSP environment plus a sample-history FIR reference.
// Filter length is shortened so the write pointer wraps many times within the cycle budget.
module tb_fir_mac_sequencer;

  localparam int N   = 37;
  localparam int AW  = $clog2(N);
  localparam int LAT = N + 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [15:0]  x_in = '0;
  logic                x_valid = 1'b0;
  logic                busy, overrun, buf_we, mac_ce, mac_first, y_valid;
  logic [AW-1:0]       buf_waddr, buf_raddr, coef_addr;
  logic [15:0]         buf_wdata;
  logic signed [15:0]  y_out;
  logic signed [47:0]  acc_in = '0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.N_TAPS(N)) dut (
    .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid),
    .busy(busy), .overrun(overrun),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata), .buf_raddr(buf_raddr),
    .coef_addr(coef_addr), .mac_ce(mac_ce), .mac_first(mac_first),
    .acc_in(acc_in), .y_out(y_out), .y_valid(y_valid)
  );

  // Datapath environment: 2-cycle RAM/ROM reads, DSP result visible 3 cycles after its last mac_ce.
  logic signed [15:0] ram [N] = '{default: 16'sh5A5A};
  logic signed [15:0] coef [N];
  logic signed [15:0] xp1 = '0, xp2 = '0, cp1 = '0, cp2 = '0;
  longint acc_r = 0, d1 = 0;

  always @(posedge clk) begin
    if (buf_we) ram[buf_waddr] <= buf_wdata;
    xp1 <= ram[buf_raddr];
    xp2 <= xp1;
    cp1 <= coef[coef_addr];
    cp2 <= cp1;
    if (mac_ce) acc_r <= (mac_first ? 64'sd0 : acc_r) + longint'(xp2) * longint'(cp2);
    d1     <= acc_r;
    acc_in <= d1[47:0];
  end

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input longint act, input longint want);
    tests++;
    if (act != want) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference model state, owned by the stimulus process.
  typedef struct { int t; longint y; } exp_t;
  exp_t        expq[$];
  longint      xs[$];
  int          n_acc, last_t, run_t, prev_t, run_w, ovr_at;
  logic [15:0] run_x;

  function automatic longint fir_ref();
    longint s = 0;
    for (int i = 0; i < xs.size(); i++) s += longint'(coef[i]) * xs[i];
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_reset();
    xs.delete();
    n_acc  = 0;
    last_t = -100000;
    run_t  = -100000;
    prev_t = -100000;
    ovr_at = 1 << 30;
  endtask

  task automatic send(input logic signed [15:0] v);
    int   t;
    exp_t e;
    t = cyc;
    if (t >= N && t >= last_t + LAT) begin
      xs.push_front(longint'(v));
      if (xs.size() > N) void'(xs.pop_back());
      prev_t = run_t;
      run_t  = t;
      run_w  = n_acc % N;
      run_x  = v;
      n_acc++;
      last_t = t;
      e.t = t + LAT;
      e.y = fir_ref();
      expq.push_back(e);
    end else if (ovr_at > t + 1) begin
      ovr_at = t + 1;
    end
    x_in    = v;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_y(output logic signed [15:0] y, output int at);
    int n = 0;
    while (!y_valid && n < LAT + 20) begin
      @(negedge clk);
      n++;
    end
    check("y_valid_wait", y_valid, 1);
    y  = y_out;
    at = cyc;
  endtask

  task automatic check_zero();
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_buf_waddr", buf_waddr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_buf_raddr", buf_raddr, 0);
    check("rst_coef_addr", coef_addr, 0);
    check("rst_mac_ce", mac_ce, 0);
    check("rst_mac_first", mac_first, 0);
    check("rst_y_out", y_out, 0);
    check("rst_y_valid", y_valid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the reference.
  int     head = 0;
  longint y_hold = 0;
  int     cc, kk;
  logic   e_busy, e_we;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        head   = expq.size();
        y_hold = 0;
      end else begin
        cc = cyc;
        e_busy = (cc >= 1 && cc <= N) || (cc >= run_t + 2 && cc <= run_t + LAT)
                 || (cc >= prev_t + 2 && cc <= prev_t + LAT);
        e_we   = (cc >= 1 && cc <= N) || (cc == run_t + 2);
        check("busy", busy, e_busy);
        check("overrun", overrun, cc >= ovr_at);
        check("buf_we", buf_we, e_we);
        if (e_we && cc <= N) begin
          check("init_waddr", buf_waddr, cc - 1);
          check("init_wdata", buf_wdata, 0);
        end else if (e_we) begin
          check("load_waddr", buf_waddr, run_w);
          check("load_wdata", buf_wdata, run_x);
        end
        if (cc >= run_t + 3 && cc <= run_t + N + 2) begin
          kk = cc - run_t - 3;
          check("buf_raddr", buf_raddr, ((run_w - kk) % N + N) % N);
          check("coef_addr", coef_addr, kk);
        end
        if (head < expq.size() && expq[head].t == cc) begin
          check("y_valid", y_valid, 1);
          check("y_out", y_out, expq[head].y);
          y_hold = expq[head].y;
          head++;
        end else begin
          check("y_valid_idle", y_valid, 0);
          check("y_out_hold", y_out, y_hold);
        end
      end
    end
  end

  task automatic rand_coefs();
    for (int i = 0; i < N; i++) coef[i] = 16'(int'($urandom_range(0, 8000)) - 4000);
  endtask

  logic signed [15:0] y;
  int t0, at;

  initial begin
    rand_coefs();
    coef[0] = 16'sh4000;
    coef[1] = -16'sh2000;
    coef[2] = 16'sd3;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_zero();
    @(negedge clk);
    rst = 1'b0;
    wait_until(N + 2);

    // Impulse through a cleared RAM; each following sample lands in the y_valid cycle.
    t0 = cyc;
    send(16'sh7FFF);
    wait_y(y, at);
    check("impulse_tap0", y, 16384);
    check("latency", at - t0, 45);
    send(16'sh0000);
    wait_y(y, at);
    check("impulse_tap1", y, -8192);
    send(16'sh0000);
    wait_y(y, at);
    check("impulse_tap2", y, 3);
    for (int i = 0; i < 6; i++) begin
      send(16'sh0000);
      wait_y(y, at);
    end

    // Random samples, always accepted; wraps the write pointer several times.
    for (int i = 0; i < 120; i++) begin
      wait_until(last_t + LAT + int'($urandom_range(0, 8)));
      send(16'($urandom));
    end

    // Saturation with a gain far above one.
    wait_until(last_t + LAT + 2);
    for (int i = 0; i < N; i++) coef[i] = 16'sh7FFF;
    for (int i = 0; i < N; i++) begin
      wait_until(last_t + LAT);
      send(16'sh7FFF);
    end
    wait_y(y, at);
    check("sat_pos", y, 32767);
    for (int i = 0; i < N; i++) begin
      wait_until(last_t + LAT);
      send(-16'sh8000);
    end
    wait_y(y, at);
    check("sat_neg", y, -32768);
    rand_coefs();

    // Second strobe 10 cycles into a run is dropped.
    wait_until(last_t + LAT + 3);
    send(16'sh1234);
    repeat (9) @(negedge clk);
    send(16'sh4321);
    wait_y(y, at);
    repeat (LAT) @(negedge clk);
    check("overrun_pin", overrun, 1);

    // Reset in the middle of the MAC phase, then a strobe during INIT.
    send(16'sh7777);
    repeat (10) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);
    send(16'sh0ABC);
    wait_until(N + 1);
    check("overrun_init", overrun, 1);

    // Random arrival times, some landing while busy.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, LAT + 10)) @(negedge clk);
      send(16'($urandom));
    end

    for (int i = 0; i < 2 * LAT && head < expq.size(); i++) @(negedge clk);
    check("all_outputs_seen", head, expq.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
